temp_zone_scheduler: RTL and testbench

- Time-shares one up/down temperature-stabilizer datapath across N_ZONES thermal zones.
- Holds per-zone threshold registers and round-robin arbitrates zone requests.
- For the granted zone: captures its temperature, steps it by ±1 per cycle into [dwn, up], then reports the settled value, cooling flag and step count over a valid/ready handshake.
- Sits between the zone sensor front-ends and the cooling/heating actuator sequencer.

---
 rtl/temp_sched_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/temp_zone_scheduler.sv | 214 +++++++++++++++++++++
 tb/tb_temp_zone_scheduler.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/temp_sched_pkg.sv
// Shared types, reset constants and the band check for the thermal-zone scheduler.
package temp_sched_pkg;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ADJUST = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Widest temperature the band-check helper handles; narrower values are zero-extended.
  localparam int MAX_DW = 32;

  // Reset thresholds: upper is all-ones, lower is all-zeros, so every temperature is in band.
  localparam logic DEF_UP_BIT  = 1'b1;
  localparam logic DEF_DWN_BIT = 1'b0;

  // True when dwn <= t <= up (unsigned).
  function automatic logic in_band(input logic [MAX_DW-1:0] t,
                                   input logic [MAX_DW-1:0] dwn,
                                   input logic [MAX_DW-1:0] up);
    return (t >= dwn) && (t <= up);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW-1:0] w_pos;

  // Scan from the pointer upwards and stop at the first active request.
  always_comb begin
    o_gnt = {N{1'b0}};
    o_idx = {IW{1'b0}};
    o_any = 1'b0;
    w_pos = {IW{1'b0}};
    for (int i = 0; i < N; i++) begin
      w_pos = IW'((int'(i_ptr) + i) % N);
      if (!o_any && i_req[w_pos]) begin
        o_any        = 1'b1;
        o_gnt[w_pos] = 1'b1;
        o_idx        = w_pos;
      end else begin
        o_any = o_any;
      end
    end
  end

endmodule

// File: rtl/temp_zone_scheduler.sv
// Shares one +/-1 temperature stabiliser across N_ZONES zones with round-robin service.
module temp_zone_scheduler
  import temp_sched_pkg::*;
#(
  parameter int N_ZONES   = 4,
  parameter int DW        = 8,
  parameter int MAX_STEPS = 255
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [N_ZONES-1:0]         zone_req,
  input  logic [N_ZONES*DW-1:0]      zone_temp,
  input  logic                       cfg_we,
  input  logic [$clog2(N_ZONES)-1:0] cfg_zone,
  input  logic [DW-1:0]              cfg_up,
  input  logic [DW-1:0]              cfg_dwn,
  output logic                       cfg_err,
  output logic [N_ZONES-1:0]         zone_gnt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(N_ZONES)-1:0] out_zone,
  output logic [DW-1:0]              out_temp,
  output logic                       out_cooling,
  output logic [DW-1:0]              out_steps,
  output logic                       out_timeout
);

  localparam int ZW = $clog2(N_ZONES);
  localparam logic [DW-1:0] STEP_LIMIT = DW'(MAX_STEPS);

  // Per-zone thresholds and config error flag
  logic [DW-1:0] r_up  [N_ZONES];
  logic [DW-1:0] r_dwn [N_ZONES];
  logic          r_cfg_err;

  // Service state
  state_t        r_state;
  logic [ZW-1:0] r_rr_ptr;
  logic [ZW-1:0] r_sel;
  logic [DW-1:0] r_work;
  logic [DW-1:0] r_cur_up;
  logic [DW-1:0] r_cur_dwn;
  logic [DW-1:0] r_steps;
  logic          r_cooling;
  logic          r_timeout;
  logic          r_valid;
  logic [N_ZONES-1:0] r_gnt;

  // Combinational helpers
  logic [DW-1:0]      w_zone_temp [N_ZONES];
  logic [N_ZONES-1:0] w_arb_gnt;
  logic [ZW-1:0]      w_arb_idx;
  logic               w_arb_any;
  logic               w_cfg_bad;
  logic               w_cfg_zone_ok;
  logic               w_in_band;
  logic               w_steps_max;
  logic               w_above;
  state_t             w_state_nxt;
  logic               w_step;
  logic               w_timeout_hit;
  logic               w_accept;
  logic [ZW-1:0]      w_ptr_nxt;

  genvar g;
  generate
    for (g = 0; g < N_ZONES; g++) begin : g_unpack
      assign w_zone_temp[g] = zone_temp[g*DW +: DW];
    end
  endgenerate

  assign w_cfg_bad     = cfg_dwn > cfg_up;
  assign w_cfg_zone_ok = int'(cfg_zone) < N_ZONES;
  assign w_in_band     = in_band(MAX_DW'(r_work), MAX_DW'(r_cur_dwn), MAX_DW'(r_cur_up));
  assign w_steps_max   = (r_steps == STEP_LIMIT);
  assign w_above       = (r_work > r_cur_up);

  rr_arbiter #(.N(N_ZONES), .IW(ZW)) u_arb (
    .i_req (zone_req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx),
    .o_any (w_arb_any)
  );

  // Threshold table: accept only ordered bands, flag inverted ones for one cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_ZONES; i++) begin
        r_up[i]  <= {DW{DEF_UP_BIT}};
        r_dwn[i] <= {DW{DEF_DWN_BIT}};
      end
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= 1'b0;
      if (cfg_we) begin
        if (w_cfg_bad) begin
          r_cfg_err <= 1'b1;
        end else if (w_cfg_zone_ok) begin
          r_up[cfg_zone]  <= cfg_up;
          r_dwn[cfg_zone] <= cfg_dwn;
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state and per-cycle control strobes.
  always_comb begin
    w_state_nxt   = r_state;
    w_step        = 1'b0;
    w_timeout_hit = 1'b0;
    w_accept      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_arb_any) w_state_nxt = LOAD;
        else           w_state_nxt = IDLE;
      end
      LOAD: w_state_nxt = ADJUST;
      ADJUST: begin
        if (w_in_band) begin
          w_state_nxt = DONE;
        end else if (w_steps_max) begin
          w_state_nxt   = DONE;
          w_timeout_hit = 1'b1;
        end else begin
          w_state_nxt = ADJUST;
          w_step      = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Round-robin pointer moves to the zone after the one just served.
  always_comb begin
    if (int'(r_sel) == N_ZONES - 1) w_ptr_nxt = {ZW{1'b0}};
    else                            w_ptr_nxt = r_sel + ZW'(1'b1);
  end

  // Service datapath: grant, capture, step towards the band, hold the result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rr_ptr  <= {ZW{1'b0}};
      r_sel     <= {ZW{1'b0}};
      r_work    <= {DW{1'b0}};
      r_cur_up  <= {DW{1'b0}};
      r_cur_dwn <= {DW{1'b0}};
      r_steps   <= {DW{1'b0}};
      r_cooling <= 1'b0;
      r_timeout <= 1'b0;
      r_valid   <= 1'b0;
      r_gnt     <= {N_ZONES{1'b0}};
    end else begin
      r_gnt <= {N_ZONES{1'b0}};
      case (r_state)
        IDLE: begin
          if (w_arb_any) begin
            r_gnt <= w_arb_gnt;
            r_sel <= w_arb_idx;
          end
        end
        LOAD: begin
          r_work    <= w_zone_temp[r_sel];
          r_cur_up  <= r_up[r_sel];
          r_cur_dwn <= r_dwn[r_sel];
          r_cooling <= w_zone_temp[r_sel] > r_up[r_sel];
          r_steps   <= {DW{1'b0}};
          r_timeout <= 1'b0;
        end
        ADJUST: begin
          if (w_timeout_hit) begin
            r_timeout <= 1'b1;
          end else if (w_step) begin
            if (w_above) r_work <= r_work - DW'(1'b1);
            else         r_work <= r_work + DW'(1'b1);
            r_steps <= r_steps + DW'(1'b1);
          end
        end
        DONE: begin
          if (w_accept) r_rr_ptr <= w_ptr_nxt;
        end
        default: r_rr_ptr <= r_rr_ptr;
      endcase
      r_valid <= (w_state_nxt == DONE);
    end
  end

  assign cfg_err     = r_cfg_err;
  assign zone_gnt    = r_gnt;
  assign out_valid   = r_valid;
  assign out_zone    = r_sel;
  assign out_temp    = r_work;
  assign out_cooling = r_cooling;
  assign out_steps   = r_steps;
  assign out_timeout = r_timeout;

endmodule

// File: tb/tb_temp_zone_scheduler.sv
// Directed self-checking bench for temp_zone_scheduler.
module tb_temp_zone_scheduler;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic [N-1:0]  zone_req;
  logic [N*DW-1:0] zone_temp;
  logic          cfg_we;
  logic [1:0]    cfg_zone;
  logic [DW-1:0] cfg_up, cfg_dwn;
  logic          cfg_err;
  logic [N-1:0]  zone_gnt;
  logic          out_valid, out_ready;
  logic [1:0]    out_zone;
  logic [DW-1:0] out_temp, out_steps;
  logic          out_cooling, out_timeout;

  // Second instance with a small step limit for the timeout path.
  logic [N-1:0]  t2_req;
  logic [N*DW-1:0] t2_temp;
  logic          t2_we;
  logic [1:0]    t2_zone_cfg;
  logic [DW-1:0] t2_up, t2_dwn;
  logic          t2_err;
  logic [N-1:0]  t2_gnt;
  logic          t2_valid, t2_ready;
  logic [1:0]    t2_zone;
  logic [DW-1:0] t2_otemp, t2_steps;
  logic          t2_cooling, t2_timeout;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  temp_zone_scheduler #(.N_ZONES(N), .DW(DW), .MAX_STEPS(255)) dut (
    .clk(clk), .rstn(rstn), .zone_req(zone_req), .zone_temp(zone_temp),
    .cfg_we(cfg_we), .cfg_zone(cfg_zone), .cfg_up(cfg_up), .cfg_dwn(cfg_dwn),
    .cfg_err(cfg_err), .zone_gnt(zone_gnt), .out_valid(out_valid),
    .out_ready(out_ready), .out_zone(out_zone), .out_temp(out_temp),
    .out_cooling(out_cooling), .out_steps(out_steps), .out_timeout(out_timeout)
  );

  temp_zone_scheduler #(.N_ZONES(N), .DW(DW), .MAX_STEPS(4)) dut2 (
    .clk(clk), .rstn(rstn), .zone_req(t2_req), .zone_temp(t2_temp),
    .cfg_we(t2_we), .cfg_zone(t2_zone_cfg), .cfg_up(t2_up), .cfg_dwn(t2_dwn),
    .cfg_err(t2_err), .zone_gnt(t2_gnt), .out_valid(t2_valid),
    .out_ready(t2_ready), .out_zone(t2_zone), .out_temp(t2_otemp),
    .out_cooling(t2_cooling), .out_steps(t2_steps), .out_timeout(t2_timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_temp(input int z, input logic [DW-1:0] v);
    zone_temp[z*DW +: DW] = v;
  endtask

  task automatic cfg_write(input logic [1:0] z, input logic [DW-1:0] up, input logic [DW-1:0] dwn);
    cfg_we = 1'b1; cfg_zone = z; cfg_up = up; cfg_dwn = dwn;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic wait_gnt(input int budget, output int cyc, output bit ok);
    ok = 1'b0; cyc = 0;
    for (int k = 0; k < budget; k++) begin
      tick(); cyc++;
      if (zone_gnt !== 4'b0000) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_valid(input int budget, output int cyc, output bit ok);
    ok = 1'b0; cyc = 0;
    for (int k = 0; k < budget; k++) begin
      tick(); cyc++;
      if (out_valid === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [25:0] obs;
    rstn = 1'b0; zone_req = '0; zone_temp = '0; cfg_we = 1'b0; cfg_zone = 2'd0;
    cfg_up = 8'd0; cfg_dwn = 8'd0; out_ready = 1'b0;
    t2_req = '0; t2_temp = '0; t2_we = 1'b0; t2_zone_cfg = 2'd0; t2_up = 8'd0; t2_dwn = 8'd0; t2_ready = 1'b0;
    repeat (3) tick();
    obs = {cfg_err, zone_gnt, out_valid, out_zone, out_temp, out_cooling, out_steps, out_timeout};
    n_vec++; if (obs !== 26'd0) begin n_err++; $display("FAIL reset_outputs: got %h want 0", obs); end
    obs = {t2_err, t2_gnt, t2_valid, t2_zone, t2_otemp, t2_cooling, t2_steps, t2_timeout};
    n_vec++; if (obs !== 26'd0) begin n_err++; $display("FAIL reset_outputs2: got %h want 0", obs); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int c; bit ok;
    set_temp(0, 8'd50);
    zone_req = 4'b0001;
    wait_gnt(10, c, ok);
    n_vec++; if (!ok || zone_gnt !== 4'b0001 || c != 1) begin n_err++; $display("FAIL basic_gnt: got %b after %0d want 0001 after 1", zone_gnt, c); end
    zone_req = 4'b0000;
    wait_valid(20, c, ok);
    n_vec++; if (!ok || c != 2) begin n_err++; $display("FAIL basic_latency: got %0d want 2", c); end
    n_vec++; if ({out_temp, out_steps, out_cooling, out_timeout, out_zone} !== {8'd50, 8'd0, 1'b0, 1'b0, 2'd0}) begin
      n_err++; $display("FAIL basic_result: got temp %0d steps %0d cool %b to %b zone %0d want 50 0 0 0 0", out_temp, out_steps, out_cooling, out_timeout, out_zone); end
    accept();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_drop: got %b want 0", out_valid); end
  endtask

  task automatic test_cfg_clip();
    int c; bit ok;
    cfg_write(2'd1, 8'd40, 8'd30);
    n_vec++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL clip_cfg_err: got %b want 0", cfg_err); end
    set_temp(1, 8'd45);
    zone_req = 4'b0010;
    wait_gnt(10, c, ok);
    n_vec++; if (!ok || zone_gnt !== 4'b0010) begin n_err++; $display("FAIL clip_gnt: got %b want 0010", zone_gnt); end
    zone_req = 4'b0000;
    wait_valid(30, c, ok);
    n_vec++; if (!ok || c != 7) begin n_err++; $display("FAIL clip_latency: got %0d want 7", c); end
    n_vec++; if ({out_temp, out_steps, out_cooling, out_timeout, out_zone} !== {8'd40, 8'd5, 1'b1, 1'b0, 2'd1}) begin
      n_err++; $display("FAIL clip_result: got temp %0d steps %0d cool %b to %b zone %0d want 40 5 1 0 1", out_temp, out_steps, out_cooling, out_timeout, out_zone); end
    accept();
  endtask

  task automatic test_round_robin(input int first, input int count, input string tag);
    int c; bit ok; int z;
    set_temp(0, 8'd50); set_temp(1, 8'd35); set_temp(2, 8'd60); set_temp(3, 8'd70);
    out_ready = 1'b1;
    zone_req = 4'b1111;
    for (int i = 0; i < count; i++) begin
      z = (first + i) % N;
      wait_gnt(40, c, ok);
      if (i == count - 1) zone_req = 4'b0000;
      n_vec++; if (!ok || zone_gnt !== (4'b0001 << z)) begin n_err++; $display("FAIL rr_%s_%0d: got %b want zone %0d", tag, i, zone_gnt, z); end
    end
    repeat (6) tick();
    out_ready = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rr_%s_idle: got valid %b want 0", tag, out_valid); end
  endtask

  task automatic test_cfg_err();
    int c; bit ok;
    cfg_write(2'd2, 8'd10, 8'd20);
    n_vec++; if (cfg_err !== 1'b1) begin n_err++; $display("FAIL cfgerr_pulse: got %b want 1", cfg_err); end
    tick();
    n_vec++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL cfgerr_clear: got %b want 0", cfg_err); end
    set_temp(2, 8'd200);
    zone_req = 4'b0100;
    wait_gnt(10, c, ok);
    zone_req = 4'b0000;
    wait_valid(30, c, ok);
    n_vec++; if (!ok || {out_temp, out_steps, out_cooling} !== {8'd200, 8'd0, 1'b0}) begin
      n_err++; $display("FAIL cfgerr_unchanged: got temp %0d steps %0d cool %b want 200 0 0", out_temp, out_steps, out_cooling); end
    accept();
    // band 90..100, then widen it while zone 2 is mid-adjust
    cfg_write(2'd2, 8'd100, 8'd90);
    n_vec++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL cfgerr_good_write: got %b want 0", cfg_err); end
    set_temp(2, 8'd110);
    zone_req = 4'b0100;
    wait_gnt(10, c, ok);
    zone_req = 4'b0000;
    tick();
    cfg_write(2'd2, 8'd200, 8'd0);
    wait_valid(40, c, ok);
    n_vec++; if (!ok || {out_temp, out_steps, out_cooling, out_zone} !== {8'd100, 8'd10, 1'b1, 2'd2}) begin
      n_err++; $display("FAIL midwrite_old: got temp %0d steps %0d cool %b zone %0d want 100 10 1 2", out_temp, out_steps, out_cooling, out_zone); end
    accept();
    zone_req = 4'b0100;
    wait_gnt(10, c, ok);
    zone_req = 4'b0000;
    wait_valid(30, c, ok);
    n_vec++; if (!ok || {out_temp, out_steps, out_cooling} !== {8'd110, 8'd0, 1'b0}) begin
      n_err++; $display("FAIL midwrite_new: got temp %0d steps %0d cool %b want 110 0 0", out_temp, out_steps, out_cooling); end
    accept();
  endtask

  task automatic test_timeout();
    int c; bit ok;
    t2_we = 1'b1; t2_zone_cfg = 2'd0; t2_up = 8'd255; t2_dwn = 8'd100;
    tick();
    t2_we = 1'b0;
    t2_temp[7:0] = 8'd0;
    t2_req = 4'b0001;
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (t2_gnt !== 4'b0000) begin ok = 1'b1; break; end
    end
    t2_req = 4'b0000;
    n_vec++; if (!ok || t2_gnt !== 4'b0001) begin n_err++; $display("FAIL timeout_gnt: got %b want 0001", t2_gnt); end
    ok = 1'b0; c = 0;
    for (int k = 0; k < 30; k++) begin
      tick(); c++;
      if (t2_valid === 1'b1) begin ok = 1'b1; break; end
    end
    n_vec++; if (!ok || c != 6) begin n_err++; $display("FAIL timeout_latency: got %0d want 6", c); end
    n_vec++; if ({t2_otemp, t2_steps, t2_timeout, t2_cooling} !== {8'd4, 8'd4, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL timeout_result: got temp %0d steps %0d to %b cool %b want 4 4 1 0", t2_otemp, t2_steps, t2_timeout, t2_cooling); end
    t2_ready = 1'b1;
    tick();
    t2_ready = 1'b0;
    n_vec++; if (t2_valid !== 1'b0) begin n_err++; $display("FAIL timeout_valid_drop: got %b want 0", t2_valid); end
  endtask

  task automatic test_hold();
    int c; bit ok;
    set_temp(3, 8'd10);
    out_ready = 1'b0;
    zone_req = 4'b1000;
    wait_gnt(10, c, ok);
    n_vec++; if (!ok || zone_gnt !== 4'b1000) begin n_err++; $display("FAIL hold_gnt: got %b want 1000", zone_gnt); end
    zone_req = 4'b0001;
    wait_valid(20, c, ok);
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++; if ({out_valid, out_temp, out_steps, out_zone, zone_gnt} !== {1'b1, 8'd10, 8'd0, 2'd3, 4'b0000}) begin
        n_err++; $display("FAIL hold_stable_%0d: got v %b temp %0d steps %0d zone %0d gnt %b want 1 10 0 3 0000", i, out_valid, out_temp, out_steps, out_zone, zone_gnt); end
    end
    accept();
    wait_gnt(10, c, ok);
    zone_req = 4'b0000;
    n_vec++; if (!ok || zone_gnt !== 4'b0001) begin n_err++; $display("FAIL hold_next_gnt: got %b want 0001", zone_gnt); end
    wait_valid(20, c, ok);
    accept();
  endtask

  task automatic test_reset_mid();
    int c; bit ok;
    logic [25:0] obs;
    cfg_write(2'd1, 8'd10, 8'd0);
    set_temp(1, 8'd100);
    zone_req = 4'b0010;
    wait_gnt(10, c, ok);
    zone_req = 4'b0000;
    repeat (3) tick();
    n_vec++; if (out_steps !== 8'd2) begin n_err++; $display("FAIL midreset_progress: got steps %0d want 2", out_steps); end
    rstn = 1'b0;
    #1;
    obs = {cfg_err, zone_gnt, out_valid, out_zone, out_temp, out_cooling, out_steps, out_timeout};
    n_vec++; if (obs !== 26'd0) begin n_err++; $display("FAIL midreset_outputs: got %h want 0", obs); end
    repeat (2) tick();
    rstn = 1'b1;
    repeat (3) tick();
    n_vec++; if (out_valid !== 1'b0 || zone_gnt !== 4'b0000) begin n_err++; $display("FAIL midreset_no_output: got v %b gnt %b want 0 0000", out_valid, zone_gnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cfg_clip();
    test_round_robin(2, 4, "from2");
    rstn = 1'b0; tick(); rstn = 1'b1; tick();
    test_round_robin(0, 5, "from0");
    test_cfg_err();
    test_timeout();
    test_hold();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1);
  end

endmodule
